pw_bit_multi_tx: RTL

Multi-channel pulse-width bit transmitter: each channel serialises words from a per-channel FIFO into a pulse-width-coded line (fixed bit period; high time selects 0 or 1). After the FIFO drains it inserts a programmable low latch gap. It is the parametrised successor to the single-word pw_bit core, adding buffering, configurable word length, bit order, polarity and a latch gap. It sits between a register/DMA front end, which drives the stream inputs, and the output pins.

---
 rtl/pw_bit_pkg.sv | 31 +++
 rtl/pw_bit_chan.sv | 171 +++++++++++++++++
 rtl/pw_bit_multi_tx.sv | 53 +++++
 3 files changed

// File: rtl/pw_bit_pkg.sv
// Shared types and helpers for the multi-channel pulse-width bit transmitter.
// Imported by the per-channel engine and the top wrapper.
package pw_bit_pkg;

    localparam int PW_WORD_WIDTH  = 32;
    localparam int PW_CNT_WIDTH   = 16;
    localparam int PW_NBITS_WIDTH = $clog2(PW_WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BIT,
        GAP
    } pw_state_t;

    // Per-word timing snapshot; field widths follow the default WORD_WIDTH/CNT_WIDTH.
    typedef struct packed {
        logic [PW_CNT_WIDTH-1:0]   period;
        logic [PW_CNT_WIDTH-1:0]   t0h;
        logic [PW_CNT_WIDTH-1:0]   t1h;
        logic [PW_CNT_WIDTH-1:0]   gap;
        logic [PW_NBITS_WIDTH-1:0] nbits;
        logic                      msb_first;
    } pw_shadow_t;

    // A word length of zero or beyond the datapath means "send the whole word".
    function automatic int unsigned clamp_nbits(input int unsigned nbits,
                                                input int unsigned word_width);
        return (nbits == 0 || nbits > word_width) ? word_width : nbits;
    endfunction

endpackage

// File: rtl/pw_bit_chan.sv
// One transmit channel: word FIFO, IDLE/BIT/GAP sequencer, bit shifter and
// registered txd/busy outputs. Config is snapshotted at every word load.
module pw_bit_chan
    import pw_bit_pkg::*;
#(
    parameter int WORD_WIDTH = PW_WORD_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = PW_CNT_WIDTH,
    parameter int NBITS_W    = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [CNT_WIDTH-1:0]  cfg_period,
    input  logic [CNT_WIDTH-1:0]  cfg_t0h,
    input  logic [CNT_WIDTH-1:0]  cfg_t1h,
    input  logic [CNT_WIDTH-1:0]  cfg_gap,
    input  logic [NBITS_W-1:0]    cfg_nbits,
    input  logic                  cfg_msb_first,
    input  logic                  cfg_invert,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic                  txd,
    output logic                  busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  push;
    logic                  pop;
    logic                  empty;

    assign empty    = (count == '0);
    assign s_tready = (count != (PTR_W+1)'(FIFO_DEPTH));
    assign push     = s_tvalid && s_tready;

    // NOTE: the storage array is deliberately not reset; pointers and count alone define valid entries.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    pw_state_t             state, state_n;
    logic [CNT_WIDTH-1:0]  cnt, cnt_n;
    logic [NBITS_W-1:0]    idx, idx_n;
    logic [WORD_WIDTH-1:0] sh, sh_n;
    pw_shadow_t            shadow, shadow_n;

    logic                  can_load;
    logic                  load;
    logic                  cur_bit;
    logic                  active;
    logic [NBITS_W-1:0]    nb_load;
    logic [CNT_WIDTH-1:0]  period_m1;
    logic [CNT_WIDTH-1:0]  gap_m1;
    logic [CNT_WIDTH-1:0]  thigh;
    logic [NBITS_W-1:0]    last_idx;

    assign can_load  = !empty && enable && (cfg_period >= CNT_WIDTH'(2));
    assign nb_load   = NBITS_W'(clamp_nbits(32'(cfg_nbits), WORD_WIDTH));
    assign period_m1 = CNT_WIDTH'(shadow.period) - CNT_WIDTH'(1);
    assign gap_m1    = CNT_WIDTH'(shadow.gap) - CNT_WIDTH'(1);
    assign last_idx  = NBITS_W'(shadow.nbits) - NBITS_W'(1);

    // MSB-first words are left-aligned and leave from the top; LSB-first leave from bit 0.
    assign cur_bit = shadow.msb_first ? sh[WORD_WIDTH-1] : sh[0];
    assign thigh   = cur_bit ? CNT_WIDTH'(shadow.t1h) : CNT_WIDTH'(shadow.t0h);
    assign active  = (state == BIT) && (cnt < thigh);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        sh_n     = sh;
        shadow_n = shadow;
        load     = 1'b0;
        pop      = 1'b0;

        case (state)
            IDLE: begin
                if (can_load) load = 1'b1;
            end
            BIT: begin
                if (cnt == period_m1) begin
                    cnt_n = '0;
                    if (idx != last_idx) begin
                        idx_n = idx + NBITS_W'(1);
                        sh_n  = shadow.msb_first ? (sh << 1) : (sh >> 1);
                    end else if (can_load) begin
                        load = 1'b1;
                    end else if (shadow.gap == '0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = GAP;
                    end
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            GAP: begin
                if (cnt == gap_m1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // A load pops the head word and freezes the timing it will be sent with.
        if (load) begin
            pop      = 1'b1;
            state_n  = BIT;
            cnt_n    = '0;
            idx_n    = '0;
            sh_n     = cfg_msb_first ? (mem[rd_ptr] << (WORD_WIDTH - int'(nb_load)))
                                     : mem[rd_ptr];
            shadow_n = '{period:    PW_CNT_WIDTH'(cfg_period),
                         t0h:       PW_CNT_WIDTH'(cfg_t0h),
                         t1h:       PW_CNT_WIDTH'(cfg_t1h),
                         gap:       PW_CNT_WIDTH'(cfg_gap),
                         nbits:     PW_NBITS_WIDTH'(nb_load),
                         msb_first: cfg_msb_first};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            shadow <= '0;
            txd    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sh     <= sh_n;
            shadow <= shadow_n;
            txd    <= active ^ cfg_invert;
            busy   <= (state != IDLE) || !empty;
        end
    end

endmodule

// File: rtl/pw_bit_multi_tx.sv
// Multi-channel pulse-width bit transmitter: NUM_CHANNELS independent
// pw_bit_chan engines sharing one set of config inputs.
module pw_bit_multi_tx
    import pw_bit_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int WORD_WIDTH   = PW_WORD_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = PW_CNT_WIDTH
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [CNT_WIDTH-1:0]               cfg_period,
    input  logic [CNT_WIDTH-1:0]               cfg_t0h,
    input  logic [CNT_WIDTH-1:0]               cfg_t1h,
    input  logic [CNT_WIDTH-1:0]               cfg_gap,
    input  logic [$clog2(WORD_WIDTH+1)-1:0]    cfg_nbits,
    input  logic                               cfg_msb_first,
    input  logic                               cfg_invert,
    input  logic [NUM_CHANNELS-1:0]            ch_enable,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] s_tdata,
    input  logic [NUM_CHANNELS-1:0]            s_tvalid,
    output logic [NUM_CHANNELS-1:0]            s_tready,
    output logic [NUM_CHANNELS-1:0]            txd,
    output logic [NUM_CHANNELS-1:0]            busy
);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        pw_bit_chan #(
            .WORD_WIDTH (WORD_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_WIDTH  (CNT_WIDTH),
            .NBITS_W    ($clog2(WORD_WIDTH + 1))
        ) u_chan (
            .aclk          (aclk),
            .areset        (areset),
            .cfg_period    (cfg_period),
            .cfg_t0h       (cfg_t0h),
            .cfg_t1h       (cfg_t1h),
            .cfg_gap       (cfg_gap),
            .cfg_nbits     (cfg_nbits),
            .cfg_msb_first (cfg_msb_first),
            .cfg_invert    (cfg_invert),
            .enable        (ch_enable[c]),
            .s_tdata       (s_tdata[c*WORD_WIDTH +: WORD_WIDTH]),
            .s_tvalid      (s_tvalid[c]),
            .s_tready      (s_tready[c]),
            .txd           (txd[c]),
            .busy          (busy[c])
        );
    end

endmodule
